// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int cntw(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/piso_bitcnt.sv
// Bit position counter for one serialized frame.
module piso_bitcnt
    import piso_pkg::*;
#(
    parameter int DWIDTH = 8,
    localparam int CNTW = cntw(DWIDTH)
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_clear,
    input  logic            i_enable,
    output logic [CNTW-1:0] o_count,
    output logic            o_last
);

    logic [CNTW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt <= '0;
        end else if (i_clear) begin
            cnt <= '0;
        end else if (i_enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_count = cnt;
    assign o_last  = (cnt == CNTW'(DWIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out front end with valid/ready input and
// frame markers; the stream advances on i_en ticks.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DWIDTH-1:0] i_data,
    output logic              o_q,
    output logic              o_q_valid,
    output logic              o_sof,
    output logic              o_eof
);

    localparam int CNTW    = cntw(DWIDTH);
    localparam int OUT_IDX = MSB_FIRST ? DWIDTH - 1 : 0;

    state_t            state, state_nxt;
    logic [DWIDTH-1:0] shreg, shreg_nxt;
    logic              sof, sof_nxt;
    logic              eof, eof_nxt;
    logic [CNTW-1:0]   cnt;
    logic              last;
    logic              adv;
    logic              accept;

    assign adv     = (state == ST_SHIFT) && i_en;
    assign o_ready = (state == ST_IDLE) || (adv && last);
    assign accept  = i_valid && o_ready;

    piso_bitcnt #(
        .DWIDTH (DWIDTH)
    ) u_bitcnt (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_clear  (accept || (adv && last)),
        .i_enable (adv && !last),
        .o_count  (cnt),
        .o_last   (last)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_IDLE;
            shreg <= '0;
            sof   <= 1'b0;
            eof   <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            sof   <= sof_nxt;
            eof   <= eof_nxt;
        end
    end

    // shreg is zeroed on the way to IDLE so o_q needs no state gating
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        sof_nxt   = sof;
        eof_nxt   = eof;
        if (adv) begin
            sof_nxt = 1'b0;
            if (last) begin
                state_nxt = ST_IDLE;
                shreg_nxt = '0;
                eof_nxt   = 1'b0;
            end else begin
                shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                eof_nxt   = (cnt == CNTW'(DWIDTH - 2));
            end
        end
        if (accept) begin
            state_nxt = ST_SHIFT;
            shreg_nxt = i_data;
            sof_nxt   = 1'b1;
            eof_nxt   = 1'b0;
        end
    end

    assign o_q       = shreg[OUT_IDX];
    assign o_q_valid = (state == ST_SHIFT);
    assign o_sof     = sof;
    assign o_eof     = eof;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances on shared inputs,
// compared against a frame-level reference model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;

    logic rdy_m, q_m, qv_m, sof_m, eof_m;
    logic rdy_l, q_l, qv_l, sof_l, eof_l;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_serializer #(.DWIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_valid(valid),
        .o_ready(rdy_m), .i_data(data), .o_q(q_m), .o_q_valid(qv_m),
        .o_sof(sof_m), .o_eof(eof_m)
    );

    piso_serializer #(.DWIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_valid(valid),
        .o_ready(rdy_l), .i_data(data), .o_q(q_l), .o_q_valid(qv_l),
        .o_sof(sof_l), .o_eof(eof_l)
    );

    // Reference model: which word is in flight and which bit index is shown
    bit         m_busy = 1'b0;
    int         m_k = 0;
    logic [7:0] m_word = 8'h00;
    bit         m_acc = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_acc  = 1'b0;
        end else begin
            m_acc = valid && (!m_busy || (m_k == 7 && en));
            if (m_busy && en) begin
                if (m_k == 7) m_busy = 1'b0;
                else m_k = m_k + 1;
            end
            if (m_acc) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_word = data;
            end
        end
    end

    task automatic test_reset();
        rstn = 1'b0; valid = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (qv_m !== 1'b0) begin errors++; $display("FAIL rst_qv got=%b want=0", qv_m); end
        checks++; if (q_m !== 1'b0) begin errors++; $display("FAIL rst_q got=%b want=0", q_m); end
        checks++; if (sof_m !== 1'b0 || eof_m !== 1'b0) begin errors++; $display("FAIL rst_marks got=%b%b want=00", sof_m, eof_m); end
        rstn = 1'b1;
        @(negedge clk); #1;
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", rdy_m); end
        checks++; if (qv_l !== 1'b0) begin errors++; $display("FAIL rst_qv_l got=%b want=0", qv_l); end
    endtask

    task automatic test_frame(input logic [7:0] w);
        logic [7:0] got_m, got_l;
        got_m = '0; got_l = '0;
        @(negedge clk);
        valid = 1'b1; data = w; en = 1'b1;
        #1;
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL frame_ready0 w=%h got=%b want=1", w, rdy_m); end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
            #1;
            got_m = {got_m[6:0], q_m};
            got_l[c-1] = q_l;
            checks++; if (qv_m !== 1'b1) begin errors++; $display("FAIL frame_qv c=%0d got=%b want=1", c, qv_m); end
            checks++; if (sof_m !== (c == 1)) begin errors++; $display("FAIL frame_sof c=%0d got=%b want=%b", c, sof_m, c == 1); end
            checks++; if (eof_m !== (c == 8)) begin errors++; $display("FAIL frame_eof c=%0d got=%b want=%b", c, eof_m, c == 8); end
        end
        checks++; if (got_m !== w) begin errors++; $display("FAIL frame_msb_bits got=%h want=%h", got_m, w); end
        checks++; if (got_l !== w) begin errors++; $display("FAIL frame_lsb_bits got=%h want=%h", got_l, w); end
        @(negedge clk); #1;
        checks++; if (qv_m !== 1'b0 || q_m !== 1'b0) begin errors++; $display("FAIL frame_end_qv got=%b q=%b want=0", qv_m, q_m); end
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL frame_end_ready got=%b want=1", rdy_m); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got;
        got = '0;
        @(negedge clk);
        valid = 1'b1; data = 8'hA5; en = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) data = 8'h3C;
            if (c == 9) valid = 1'b0;
            #1;
            got = {got[14:0], q_m};
            checks++; if (qv_m !== 1'b1) begin errors++; $display("FAIL b2b_qv c=%0d got=%b want=1", c, qv_m); end
            checks++; if (rdy_m !== (c == 8 || c == 16)) begin errors++; $display("FAIL b2b_ready c=%0d got=%b want=%b", c, rdy_m, c == 8 || c == 16); end
            checks++; if (sof_m !== (c == 1 || c == 9)) begin errors++; $display("FAIL b2b_sof c=%0d got=%b", c, sof_m); end
            checks++; if (eof_m !== (c == 8 || c == 16)) begin errors++; $display("FAIL b2b_eof c=%0d got=%b", c, eof_m); end
        end
        checks++; if (got !== 16'hA53C) begin errors++; $display("FAIL b2b_bits got=%h want=a53c", got); end
    endtask

    task automatic test_en_pattern();
        logic [7:0] got;
        int n;
        logic prev_q, prev_en;
        got = '0; n = 0; prev_q = 1'b0; prev_en = 1'b1;
        @(negedge clk);
        valid = 1'b1; data = 8'hF0; en = 1'b0;
        #1;
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL en_ready_idle got=%b want=1", rdy_m); end
        for (int c = 1; c <= 40 && n < 8; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
            en = ((c - 1) % 3 == 0);
            #1;
            checks++; if (qv_m !== 1'b1) begin errors++; $display("FAIL en_qv c=%0d got=%b want=1", c, qv_m); end
            if (!prev_en) begin
                checks++; if (q_m !== prev_q) begin errors++; $display("FAIL en_hold c=%0d got=%b want=%b", c, q_m, prev_q); end
            end
            if (en) begin
                got = {got[6:0], q_m};
                n++;
            end
            prev_q = q_m; prev_en = en;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL en_timeout got=%0d want=8 bits", n); end
        checks++; if (got !== 8'hF0) begin errors++; $display("FAIL en_bits got=%h want=f0", got); end
        en = 1'b1;
        @(negedge clk); #1;
        checks++; if (qv_m !== 1'b0) begin errors++; $display("FAIL en_end_qv got=%b want=0", qv_m); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        valid = 1'b1; data = 8'hFF; en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
        end
        #1;
        checks++; if (q_m !== 1'b1) begin errors++; $display("FAIL rmid_bit3 got=%b want=1", q_m); end
        #1 rstn = 1'b0;
        #1;
        checks++; if ({q_m, qv_m, sof_m, eof_m} !== 4'b0) begin errors++; $display("FAIL rmid_outs_m got=%b want=0000", {q_m, qv_m, sof_m, eof_m}); end
        checks++; if ({q_l, qv_l, sof_l, eof_l} !== 4'b0) begin errors++; $display("FAIL rmid_outs_l got=%b want=0000", {q_l, qv_l, sof_l, eof_l}); end
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b want=1", rdy_m); end
        @(negedge clk);
        rstn = 1'b1;
        test_frame(8'h81);
    endtask

    task automatic test_hold_valid();
        logic [7:0] w1, w2, got;
        w1 = 8'($urandom); w2 = 8'($urandom); got = '0;
        @(negedge clk);
        valid = 1'b1; data = w1; en = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1 || c == 9) valid = 1'b0;
            if (c >= 5 && c <= 7) begin valid = 1'b1; data = 8'($urandom); end
            if (c == 8) data = w2;
            #1;
            got = {got[6:0], q_m};
            if (c == 8) begin
                checks++; if (got !== w1) begin errors++; $display("FAIL hold_first got=%h want=%h", got, w1); end
            end
            checks++; if (rdy_m !== (c == 8 || c == 16)) begin errors++; $display("FAIL hold_ready c=%0d got=%b want=%b", c, rdy_m, c == 8 || c == 16); end
        end
        checks++; if (got !== w2) begin errors++; $display("FAIL hold_second got=%h want=%h", got, w2); end
    endtask

    task automatic test_random();
        logic e_qm, e_ql, e_rdy;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
            if (!(valid && !m_acc)) begin
                valid = $urandom_range(0, 1) == 1;
                data  = 8'($urandom);
            end
            #1;
            e_qm  = m_busy ? m_word[7 - m_k] : 1'b0;
            e_ql  = m_busy ? m_word[m_k] : 1'b0;
            e_rdy = !m_busy || (m_k == 7 && en);
            checks++; if (q_m !== e_qm) begin errors++; $display("FAIL rnd_q_m c=%0d got=%b want=%b", c, q_m, e_qm); end
            checks++; if (q_l !== e_ql) begin errors++; $display("FAIL rnd_q_l c=%0d got=%b want=%b", c, q_l, e_ql); end
            checks++; if (qv_m !== m_busy) begin errors++; $display("FAIL rnd_qv c=%0d got=%b want=%b", c, qv_m, m_busy); end
            checks++; if (sof_m !== (m_busy && m_k == 0)) begin errors++; $display("FAIL rnd_sof c=%0d got=%b", c, sof_m); end
            checks++; if (eof_m !== (m_busy && m_k == 7)) begin errors++; $display("FAIL rnd_eof c=%0d got=%b", c, eof_m); end
            checks++; if (rdy_m !== e_rdy || rdy_l !== e_rdy) begin errors++; $display("FAIL rnd_ready c=%0d got=%b%b want=%b", c, rdy_m, rdy_l, e_rdy); end
        end
        valid = 1'b0;
        en = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5);
        test_back_to_back();
        test_en_pattern();
        test_frame(8'h01);
        test_reset_mid();
        test_hold_valid();
        for (int i = 0; i < 4; i++) test_frame(8'($urandom));
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
